// File: rtl/seg_display_scheduler.sv
// Time-shares one 8-digit seven-segment display among NUM_SRC value producers:
// timed round-robin over active sources, manual advance, and alert preemption.
module seg_display_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int ALERT_HOLD   = 100_000_000,
    localparam int SW          = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*32-1:0] src_val,
    input  logic [NUM_SRC-1:0]    src_active,
    input  logic [NUM_SRC-1:0]    alert,
    input  logic                  next_btn,
    input  logic                  auto_en,
    output logic [31:0]           disp_val,
    output logic [SW-1:0]         disp_src,
    output logic                  disp_blank,
    output logic                  in_alert
);

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        ALERT
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] saved_sel_q, saved_sel_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   disp_val_q, disp_val_d;
    logic [SW-1:0] disp_src_q, disp_src_d;
    logic          disp_blank_q, disp_blank_d;
    logic          in_alert_q, in_alert_d;

    logic [31:0]   src_words [NUM_SRC];
    logic [SW-1:0] alert_chain [NUM_SRC+1];
    logic [SW-1:0] na_chain [NUM_SRC][1:NUM_SRC+1];
    logic [SW-1:0] na_tab [NUM_SRC];
    logic [SW-1:0] alert_low;
    logic          any_active;
    logic          any_alert;

    // Lowest set alert index: chain from the top so lower indices override.
    assign alert_chain[NUM_SRC] = '0;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_words[gi]   = src_val[32*gi +: 32];
            assign alert_chain[gi] = alert[gi] ? SW'(gi) : alert_chain[gi+1];

            // na_tab[i] = first active index after i, wrapping, i itself checked last.
            assign na_chain[gi][NUM_SRC+1] = SW'(gi);
            for (gj = 1; gj <= NUM_SRC; gj++) begin : g_off
                localparam int J = (gi + gj) % NUM_SRC;
                assign na_chain[gi][gj] = src_active[J] ? SW'(J) : na_chain[gi][gj+1];
            end
            assign na_tab[gi] = na_chain[gi][1];
        end
    endgenerate

    assign alert_low  = alert_chain[0];
    assign any_active = |src_active;
    assign any_alert  = |alert;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        saved_sel_d = saved_sel_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (any_alert) begin
                    state_d     = ALERT;
                    sel_d       = alert_low;
                    saved_sel_d = '0;
                    cnt_d       = '0;
                end else if (any_active) begin
                    state_d = ROTATE;
                    sel_d   = na_tab[NUM_SRC-1];
                    cnt_d   = '0;
                end
            end
            ROTATE: begin
                if (any_alert) begin
                    state_d     = ALERT;
                    saved_sel_d = sel_q;
                    sel_d       = alert_low;
                    cnt_d       = '0;
                end else if (!any_active) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!src_active[sel_q] || next_btn ||
                             (auto_en && cnt_q == 32'(DWELL_CYCLES - 1))) begin
                    sel_d = na_tab[sel_q];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'(auto_en);
                end
            end
            ALERT: begin
                if (any_alert) begin
                    sel_d = alert_low;
                    cnt_d = '0;
                end else if (next_btn || cnt_q == 32'(ALERT_HOLD - 1)) begin
                    cnt_d = '0;
                    if (!any_active) begin
                        state_d = IDLE;
                    end else if (src_active[saved_sel_q]) begin
                        state_d = ROTATE;
                        sel_d   = saved_sel_q;
                    end else begin
                        state_d = ROTATE;
                        sel_d   = na_tab[saved_sel_q];
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the selection taking effect this edge.
        disp_src_d   = sel_d;
        disp_blank_d = (state_d == IDLE);
        disp_val_d   = (state_d == IDLE) ? 32'd0 : src_words[sel_d];
        in_alert_d   = (state_d == ALERT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            saved_sel_q  <= '0;
            cnt_q        <= '0;
            disp_val_q   <= '0;
            disp_src_q   <= '0;
            disp_blank_q <= 1'b1;
            in_alert_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            saved_sel_q  <= saved_sel_d;
            cnt_q        <= cnt_d;
            disp_val_q   <= disp_val_d;
            disp_src_q   <= disp_src_d;
            disp_blank_q <= disp_blank_d;
            in_alert_q   <= in_alert_d;
        end
    end

    assign disp_val   = disp_val_q;
    assign disp_src   = disp_src_q;
    assign disp_blank = disp_blank_q;
    assign in_alert   = in_alert_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed scoreboard bench: stimulus queues the expected display state per edge,
// a negedge monitor pops and compares against the DUT outputs.
module tb_seg_display_scheduler;

    localparam int NUM_SRC = 4;
    localparam int SW      = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_SRC*32-1:0] src_val;
    logic [NUM_SRC-1:0]    src_active;
    logic [NUM_SRC-1:0]    alert;
    logic                  next_btn;
    logic                  auto_en;
    logic [31:0]           disp_val;
    logic [SW-1:0]         disp_src;
    logic                  disp_blank;
    logic                  in_alert;

    logic [31:0] vals [NUM_SRC];
    assign src_val = {vals[3], vals[2], vals[1], vals[0]};

    seg_display_scheduler #(
        .NUM_SRC     (NUM_SRC),
        .DWELL_CYCLES(4),
        .ALERT_HOLD  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_val   (src_val),
        .src_active(src_active),
        .alert     (alert),
        .next_btn  (next_btn),
        .auto_en   (auto_en),
        .disp_val  (disp_val),
        .disp_src  (disp_src),
        .disp_blank(disp_blank),
        .in_alert  (in_alert)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  src;
        logic [31:0] val;
        logic        blank;
        logic        alrt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatch = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the DUT presents a fresh display state after every edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_compared++;
            if (e.cyc < cyc) begin
                n_mismatch++;
                $display("FAIL missed_check cyc=%0d: expectation for cycle %0d was never compared", cyc, e.cyc);
            end else if (disp_src !== e.src || disp_val !== e.val ||
                         disp_blank !== e.blank || in_alert !== e.alrt) begin
                n_mismatch++;
                $display("FAIL display cyc=%0d: got src=%0d val=%h blank=%b alert=%b, want src=%0d val=%h blank=%b alert=%b",
                         cyc, disp_src, disp_val, disp_blank, in_alert, e.src, e.val, e.blank, e.alrt);
            end else begin
                $display("cyc=%0d ok src=%0d val=%h blank=%b alert=%b",
                         cyc, disp_src, disp_val, disp_blank, in_alert);
            end
        end
    end

    // Queue the expected outputs after the next edge, then advance one cycle.
    task automatic step(input int src, input logic blank, input logic alrt);
        exp_t e;
        e.cyc   = cyc + 1;
        e.src   = 2'(src);
        e.val   = blank ? 32'd0 : vals[src];
        e.blank = blank;
        e.alrt  = alrt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int rot_order[3];
        rot_order = '{0, 1, 3};
        for (int k = 0; k < NUM_SRC; k++) vals[k] = 32'hA000_0000 | 32'(k);
        rst = 1'b1; src_active = '0; alert = '0; next_btn = 1'b0; auto_en = 1'b1;

        // Reset state
        step(0, 1, 0);
        step(0, 1, 0);

        // Auto rotation over {0,1,3}, dwell 4
        rst = 1'b0; src_active = 4'b1011;
        for (int r = 0; r < 3; r++) repeat (4) step(rot_order[r], 0, 0);
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);

        // Simultaneous alert[3] and alert[2] while showing src 1
        alert = 4'b1100; step(2, 0, 1); alert = '0;
        repeat (5) step(2, 0, 1);
        repeat (4) step(1, 0, 0);
        step(3, 0, 0);

        // Retarget at hold cycle 3 restarts the hold window
        alert = 4'b0100; step(2, 0, 1); alert = '0;
        repeat (3) step(2, 0, 1);
        alert = 4'b0001; step(0, 0, 1); alert = '0;
        repeat (5) step(0, 0, 1);
        step(3, 0, 0);

        // next_btn exits ALERT early back to the saved source
        alert = 4'b0010; step(1, 0, 1); alert = '0;
        step(1, 0, 1);
        next_btn = 1'b1; step(3, 0, 0); next_btn = 1'b0;

        // Manual advance only with auto_en low
        auto_en = 1'b0;
        repeat (6) step(3, 0, 0);
        next_btn = 1'b1; step(0, 0, 0); next_btn = 1'b0;
        repeat (3) step(0, 0, 0);
        next_btn = 1'b1; step(1, 0, 0); step(3, 0, 0); step(0, 0, 0); next_btn = 1'b0;

        // Current source drops out of the active set
        src_active = 4'b1010; step(1, 0, 0);

        // Live value tracking
        vals[1] = 32'h1234_5678; step(1, 0, 0);
        vals[1] = 32'hA000_0001; step(1, 0, 0);

        // Alert on an inactive source; saved source goes inactive; hold ignores auto_en
        alert = 4'b0001; step(0, 0, 1); alert = '0; src_active = 4'b1000;
        repeat (5) step(0, 0, 1);
        step(3, 0, 0);

        // No active sources -> blank; re-activation
        src_active = '0; step(3, 1, 0); step(3, 1, 0);
        src_active = 4'b0100; step(2, 0, 0);
        src_active = '0; step(2, 1, 0);

        // Alert from IDLE: saved index is 0
        alert = 4'b0010; step(1, 0, 1); alert = '0; src_active = 4'b0001;
        repeat (5) step(1, 0, 1);
        step(0, 0, 0);

        // Reset mid-ALERT
        alert = 4'b1000; step(3, 0, 1); alert = '0;
        step(3, 0, 1);
        rst = 1'b1; step(0, 1, 0);
        rst = 1'b0; step(0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_compared++;
            n_mismatch++;
            $display("FAIL unchecked: expectation for cycle %0d never compared", e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
